// File: rtl/checker_pkg.sv
// Shared constants and helpers for the result checker.
// Counters are widened to SatW bits so a single saturating increment serves every CNT_W.
package checker_pkg;

  localparam int unsigned DefWidth = 5;
  localparam int unsigned DefCntW  = 16;
  localparam int unsigned SatW     = 64;
  localparam logic [SatW-1:0] SatOnes = '1;

  // Increment 'value', holding at the all-ones pattern of a 'width'-bit counter.
  function automatic logic [SatW-1:0] sat_inc(input logic [SatW-1:0] value,
                                              input int unsigned    width);
    logic [SatW-1:0] ones;
    ones = (width >= SatW) ? SatOnes : ((SatW'(1) << width) - SatW'(1));
    return (value >= ones) ? value : value + SatW'(1);
  endfunction

endpackage

// File: rtl/delay_line.sv
// LAT-stage falling-edge shift register. The MSB of each stage is a valid bit:
// a synchronous clear drops all valid bits, while the data bits keep shifting.
module delay_line #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned LAT   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [LAT];

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= {din[WIDTH-1] & ~clear, din[WIDTH-2:0]};
      for (int i = 1; i < LAT; i++) begin
        stage_q[i] <= {stage_q[i-1][WIDTH-1] & ~clear, stage_q[i-1][WIDTH-2:0]};
      end
    end
  end

  assign dout = stage_q[LAT-1];

endmodule

// File: rtl/result_checker.sv
// Aligns a golden stream to a DUT stream through a LAT-edge delay line and compares
// them under a mask; counts compares/mismatches and captures the first failing sample.
module result_checker
  import checker_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned LAT   = 2,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] goodresult,
  input  logic [WIDTH-1:0] myresult,
  input  logic [WIDTH-1:0] mask,
  output logic             error,
  output logic             err_sticky,
  output logic [CNT_W-1:0] cmp_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] first_good,
  output logic [WIDTH-1:0] first_my,
  output logic [CNT_W-1:0] first_idx
);

  logic [WIDTH:0]   aligned;
  logic             v_d;
  logic [WIDTH-1:0] g_d;

  generate
    if (LAT == 0) begin : g_bypass
      assign aligned = {valid_in, goodresult};
    end else begin : g_delay
      delay_line #(
        .WIDTH (WIDTH + 1),
        .LAT   (LAT)
      ) u_delay_line (
        .CLK   (CLK),
        .RST   (RST),
        .clear (clear),
        .din   ({valid_in, goodresult}),
        .dout  (aligned)
      );
    end
  endgenerate

  assign v_d = aligned[WIDTH];
  assign g_d = aligned[WIDTH-1:0];

  logic             error_q,  error_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cmp_q,    cmp_d;
  logic [CNT_W-1:0] errc_q,   errc_d;
  logic [WIDTH-1:0] fgood_q,  fgood_d;
  logic [WIDTH-1:0] fmy_q,    fmy_d;
  logic [CNT_W-1:0] fidx_q,   fidx_d;
  logic             mis;

  assign mis = |((g_d ^ myresult) & mask);

  always_comb begin
    error_d  = error_q;
    sticky_d = sticky_q;
    cmp_d    = cmp_q;
    errc_d   = errc_q;
    fgood_d  = fgood_q;
    fmy_d    = fmy_q;
    fidx_d   = fidx_q;
    if (clear) begin
      // Clear wins over a coincident compare; that sample is dropped.
      error_d  = 1'b0;
      sticky_d = 1'b0;
      cmp_d    = '0;
      errc_d   = '0;
      fgood_d  = '0;
      fmy_d    = '0;
      fidx_d   = '0;
    end else if (v_d) begin
      error_d = mis;
      cmp_d   = CNT_W'(sat_inc(SatW'(cmp_q), CNT_W));
      if (mis) begin
        errc_d = CNT_W'(sat_inc(SatW'(errc_q), CNT_W));
        if (!sticky_q) begin
          sticky_d = 1'b1;
          fgood_d  = g_d;
          fmy_d    = myresult;
          fidx_d   = cmp_q;
        end
      end
    end else begin
      error_d = 1'b0;
    end
  end

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      error_q  <= 1'b0;
      sticky_q <= 1'b0;
      cmp_q    <= '0;
      errc_q   <= '0;
      fgood_q  <= '0;
      fmy_q    <= '0;
      fidx_q   <= '0;
    end else begin
      error_q  <= error_d;
      sticky_q <= sticky_d;
      cmp_q    <= cmp_d;
      errc_q   <= errc_d;
      fgood_q  <= fgood_d;
      fmy_q    <= fmy_d;
      fidx_q   <= fidx_d;
    end
  end

  assign error      = error_q;
  assign err_sticky = sticky_q;
  assign cmp_count  = cmp_q;
  assign err_count  = errc_q;
  assign first_good = fgood_q;
  assign first_my   = fmy_q;
  assign first_idx  = fidx_q;

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: a 16-bit-counter and a 3-bit-counter instance share one stimulus
// stream, checked every edge against a queue-based reference model.
module tb_result_checker;

  localparam int unsigned Lat = 2;

  logic       CLK = 1'b1;
  logic       RST = 1'b0;
  logic       clear = 1'b0;
  logic       valid_in = 1'b0;
  logic [4:0] goodresult = '0;
  logic [4:0] myresult = '0;
  logic [4:0] mask = '0;

  logic        error_a, sticky_a, error_b, sticky_b;
  logic [15:0] cmp_a, errc_a, fidx_a;
  logic [2:0]  cmp_b, errc_b, fidx_b;
  logic [4:0]  fg_a, fm_a, fg_b, fm_b;

  always #5 CLK = ~CLK;

  result_checker #(.WIDTH(5), .LAT(Lat), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .clear(clear), .valid_in(valid_in), .goodresult(goodresult),
    .myresult(myresult), .mask(mask), .error(error_a), .err_sticky(sticky_a),
    .cmp_count(cmp_a), .err_count(errc_a), .first_good(fg_a), .first_my(fm_a),
    .first_idx(fidx_a)
  );

  result_checker #(.WIDTH(5), .LAT(Lat), .CNT_W(3)) dut_b (
    .CLK(CLK), .RST(RST), .clear(clear), .valid_in(valid_in), .goodresult(goodresult),
    .myresult(myresult), .mask(mask), .error(error_b), .err_sticky(sticky_b),
    .cmp_count(cmp_b), .err_count(errc_b), .first_good(fg_b), .first_my(fm_b),
    .first_idx(fidx_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: in-flight samples {valid, golden} and the bit flip the DUT applies.
  logic [5:0]  q [$];
  logic [4:0]  fq [$];
  logic        m_err, m_sticky;
  logic [4:0]  m_fg, m_fm;
  int unsigned m_cmp [2];
  int unsigned m_errc [2];
  int unsigned m_fidx [2];
  int unsigned cmax [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    fq.delete();
    for (int i = 0; i < Lat; i++) begin
      q.push_back(6'd0);
      fq.push_back(5'd0);
    end
    m_err = 1'b0;
    m_sticky = 1'b0;
    m_fg = '0;
    m_fm = '0;
    for (int k = 0; k < 2; k++) begin
      m_cmp[k] = 0;
      m_errc[k] = 0;
      m_fidx[k] = 0;
    end
  endtask

  task automatic model_edge(input logic [4:0] flip);
    logic [5:0] al;
    logic [4:0] unused_flip;
    logic       mis;
    al = q.pop_front();
    unused_flip = fq.pop_front();
    q.push_back({valid_in & ~clear, goodresult});
    fq.push_back(flip);
    if (clear) begin
      for (int i = 0; i < q.size(); i++) q[i] = {1'b0, q[i][4:0]};
      m_err = 1'b0;
      m_sticky = 1'b0;
      m_fg = '0;
      m_fm = '0;
      for (int k = 0; k < 2; k++) begin
        m_cmp[k] = 0;
        m_errc[k] = 0;
        m_fidx[k] = 0;
      end
    end else if (al[5]) begin
      mis = ((al[4:0] ^ myresult) & mask) != 5'd0;
      for (int k = 0; k < 2; k++) begin
        if (mis && !m_sticky) m_fidx[k] = m_cmp[k];
        if (m_cmp[k] < cmax[k]) m_cmp[k]++;
        if (mis && m_errc[k] < cmax[k]) m_errc[k]++;
      end
      if (mis && !m_sticky) begin
        m_sticky = 1'b1;
        m_fg = al[4:0];
        m_fm = myresult;
      end
      m_err = mis;
    end else begin
      m_err = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".error_a"},  32'(error_a),  32'(m_err));
    chk({tag, ".sticky_a"}, 32'(sticky_a), 32'(m_sticky));
    chk({tag, ".cmp_a"},    32'(cmp_a),    m_cmp[0]);
    chk({tag, ".errc_a"},   32'(errc_a),   m_errc[0]);
    chk({tag, ".fg_a"},     32'(fg_a),     32'(m_fg));
    chk({tag, ".fm_a"},     32'(fm_a),     32'(m_fm));
    chk({tag, ".fidx_a"},   32'(fidx_a),   m_fidx[0]);
    chk({tag, ".error_b"},  32'(error_b),  32'(m_err));
    chk({tag, ".sticky_b"}, 32'(sticky_b), 32'(m_sticky));
    chk({tag, ".cmp_b"},    32'(cmp_b),    m_cmp[1]);
    chk({tag, ".errc_b"},   32'(errc_b),   m_errc[1]);
    chk({tag, ".fg_b"},     32'(fg_b),     32'(m_fg));
    chk({tag, ".fm_b"},     32'(fm_b),     32'(m_fm));
    chk({tag, ".fidx_b"},   32'(fidx_b),   m_fidx[1]);
  endtask

  // One falling edge: 'flip' is what the DUT side will corrupt this sample by when it is compared.
  task automatic cycle(input string tag, input logic v, input logic [4:0] g,
                       input logic [4:0] flip, input logic [4:0] m, input logic clr);
    valid_in   = v;
    goodresult = g;
    mask       = m;
    clear      = clr;
    myresult   = q[0][4:0] ^ fq[0];
    @(negedge CLK);
    model_edge(flip);
    #1;
    check_all(tag);
  endtask

  initial begin
    cmax[0] = 65535;
    cmax[1] = 7;
    model_reset();
    #2;
    check_all("reset");
    RST = 1'b1;

    // All-matching stream.
    for (int i = 0; i < 8; i++) cycle("match", 1'b1, 5'(i), 5'h00, 5'h1F, 1'b0);
    for (int i = 0; i < Lat; i++) cycle("match_flush", 1'b0, 5'h00, 5'h00, 5'h1F, 1'b0);
    chk("match.cmp", 32'(cmp_a), 32'd8);
    chk("match.errc", 32'(errc_a), 32'd0);

    // Single mismatch at index 3.
    cycle("clr1", 1'b0, 5'h00, 5'h00, 5'h1F, 1'b1);
    for (int i = 0; i < 8; i++)
      cycle("mis1", 1'b1, (i == 3) ? 5'h0A : 5'(i), (i == 3) ? 5'h01 : 5'h00, 5'h1F, 1'b0);
    for (int i = 0; i < Lat; i++) cycle("mis1_flush", 1'b0, 5'h00, 5'h00, 5'h1F, 1'b0);
    chk("mis1.errc", 32'(errc_a), 32'd1);
    chk("mis1.fg", 32'(fg_a), 32'h0A);
    chk("mis1.fm", 32'(fm_a), 32'h0B);
    chk("mis1.fidx", 32'(fidx_a), 32'd3);

    // Same mismatch hidden by the mask.
    cycle("clr2", 1'b0, 5'h00, 5'h00, 5'h1E, 1'b1);
    for (int i = 0; i < 8; i++)
      cycle("masked", 1'b1, (i == 3) ? 5'h0A : 5'(i), (i == 3) ? 5'h01 : 5'h00, 5'h1E, 1'b0);
    for (int i = 0; i < Lat; i++) cycle("masked_flush", 1'b0, 5'h00, 5'h00, 5'h1E, 1'b0);
    chk("masked.errc", 32'(errc_a), 32'd0);
    chk("masked.cmp", 32'(cmp_a), 32'd8);

    // Two mismatches; the first capture must stick.
    cycle("clr3", 1'b0, 5'h00, 5'h00, 5'h1F, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i == 2)      cycle("two", 1'b1, 5'h04, 5'h01, 5'h1F, 1'b0);
      else if (i == 6) cycle("two", 1'b1, 5'h10, 5'h10, 5'h1F, 1'b0);
      else             cycle("two", 1'b1, 5'($urandom), 5'h00, 5'h1F, 1'b0);
    end
    for (int i = 0; i < Lat; i++) cycle("two_flush", 1'b0, 5'h00, 5'h00, 5'h1F, 1'b0);
    chk("two.errc", 32'(errc_a), 32'd2);
    chk("two.fg", 32'(fg_a), 32'h04);
    chk("two.fm", 32'(fm_a), 32'h05);
    chk("two.fidx", 32'(fidx_a), 32'd2);

    // Saturation of the 3-bit counters.
    cycle("clr4", 1'b0, 5'h00, 5'h00, 5'h1F, 1'b1);
    for (int i = 0; i < 10; i++)
      cycle("sat", 1'b1, 5'($urandom), 5'($urandom_range(1, 31)), 5'h1F, 1'b0);
    for (int i = 0; i < Lat; i++) cycle("sat_flush", 1'b0, 5'h00, 5'h00, 5'h1F, 1'b0);
    chk("sat.cmp_b", 32'(cmp_b), 32'd7);
    chk("sat.errc_b", 32'(errc_b), 32'd7);
    chk("sat.fidx_b", 32'(fidx_b), 32'd0);
    chk("sat.cmp_a", 32'(cmp_a), 32'd10);

    // Clear coincident with a mismatching compare.
    cycle("clr5", 1'b0, 5'h00, 5'h00, 5'h1F, 1'b1);
    cycle("pre", 1'b1, 5'h03, 5'h00, 5'h1F, 1'b0);
    cycle("pre", 1'b1, 5'h07, 5'h02, 5'h1F, 1'b0);
    cycle("pre", 1'b1, 5'h09, 5'h00, 5'h1F, 1'b0);
    cycle("clr_hit", 1'b1, 5'h0C, 5'h00, 5'h1F, 1'b1);
    chk("clr_hit.error", 32'(error_a), 32'd0);
    chk("clr_hit.cmp", 32'(cmp_a), 32'd0);
    chk("clr_hit.sticky", 32'(sticky_a), 32'd0);
    for (int i = 0; i < Lat; i++) cycle("clr_flush", 1'b0, 5'h00, 5'h00, 5'h1F, 1'b0);

    // Asynchronous reset between edges with samples in flight.
    cycle("inflight", 1'b1, 5'h11, 5'h01, 5'h1F, 1'b0);
    cycle("inflight", 1'b1, 5'h12, 5'h00, 5'h1F, 1'b0);
    cycle("inflight", 1'b1, 5'h13, 5'h00, 5'h1F, 1'b0);
    valid_in = 1'b0;
    #2;
    RST = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    RST = 1'b1;
    cycle("post_rst", 1'b1, 5'h15, 5'h00, 5'h1F, 1'b0);
    chk("post_rst.cmp0", 32'(cmp_a), 32'd0);
    cycle("post_rst", 1'b0, 5'h00, 5'h00, 5'h1F, 1'b0);
    chk("post_rst.cmp1", 32'(cmp_a), 32'd0);
    cycle("post_rst", 1'b0, 5'h00, 5'h00, 5'h1F, 1'b0);
    chk("post_rst.cmp2", 32'(cmp_a), 32'd1);

    // Random mix of valids, flips, masks (incl. all-zero) and clears.
    for (int i = 0; i < 200; i++) begin
      logic       v, clr;
      logic [4:0] g, flip, m;
      v    = ($urandom_range(0, 3) != 0);
      g    = 5'($urandom);
      flip = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00;
      m    = ($urandom_range(0, 9) == 0) ? 5'h00 : 5'($urandom);
      clr  = ($urandom_range(0, 24) == 0);
      cycle("rand", v, g, flip, m, clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
- Parametrised self-checking block for the arithmetic-unit datapath.
- Aligns a golden result stream to a DUT result stream with a configurable latency delay line, then compares the two under a bit mask.
- Counts compares and mismatches, flags errors, and captures the first failing sample.
- Synthesisable; can be instantiated on-chip as a BIST monitor or in the bench.

Parameters:
- WIDTH, 5, result width in bits.
- LAT, 2, pipeline delay in clock edges applied to the golden stream (0 allowed = no delay).
- CNT_W, 16, width of the compare and error counters.

Ports:
- CLK  input  1  clock; all state updates on the falling edge.
- RST  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous clear of counters, flags and capture registers.
- valid_in  input  1  qualifies goodresult this cycle.
- goodresult  input  WIDTH  golden (expected) result.
- myresult  input  WIDTH  DUT result, checked LAT edges after the matching goodresult.
- mask  input  WIDTH  1 = bit is compared; sampled at compare time.
- error  output  1  registered per-sample mismatch flag.
- err_sticky  output  1  set on the first mismatch, held until clear or reset.
- cmp_count  output  CNT_W  number of compared samples.
- err_count  output  CNT_W  number of mismatching samples.
- first_good  output  WIDTH  aligned golden value at the first mismatch.
- first_my  output  WIDTH  DUT value at the first mismatch.
- first_idx  output  CNT_W  cmp_count value at the first mismatch.

Behaviour:
- Reset (RST=0, asynchronous): every output and internal register goes to 0, including all delay-line valid and data stages.
- Delay line:
  - LAT stages of {valid, data}, each shifting on the negedge.
  - Aligned pair = (v_d, g_d) = valid_in/goodresult delayed by LAT edges.
  - LAT=0: aligned pair = current inputs, no stage registers.
- Compare: on a negedge with v_d=1 and clear=0:
  - mis = |((g_d ^ myresult) & mask).
  - error <= mis.
  - cmp_count <= cmp_count+1.
  - If mis=1: err_count <= err_count+1.
  - If mis=1 and err_sticky=0: first_good<=g_d, first_my<=myresult, first_idx<=cmp_count (pre-increment value), err_sticky<=1.
- Negedge with v_d=0: error <= 0; counters, sticky and capture registers hold.
- Counters saturate at all-ones and never wrap. A saturated cmp_count is still used for first_idx.
- mask all-zero: a sample is counted as compared and never mismatches.
- clear=1 on a negedge:
  - Zeroes error, err_sticky, both counters, capture registers and all delay-line valid bits.
  - Takes priority over a coincident compare; that sample is discarded.
  - Samples entering valid_in on the clear edge are also discarded.
- Reset mid-stream: in-flight delay-line samples are lost. After release, the first compare occurs no earlier than LAT edges after the next valid_in.
- Latency:
  - error/counters update on the same negedge that samples myresult.
  - They are visible from that edge until the next negedge.
- No combinational path from any input to any output.

Decomposition:
- Shared package `checker_pkg` holds:
  - default WIDTH/CNT_W constants;
  - a saturating-increment function;
  - a localparam for counter all-ones.
- One natural sub-module: `delay_line` (parametrised WIDTH+1 bits, LAT stages, negedge, async active-low reset, sync clear of valid bits). Instantiated once for {valid_in, goodresult}; generate-bypassed when LAT=0.

Test Plan:
- Reset then LAT=2, 8 matching samples 5'h00..5'h07, mask=5'h1F -> cmp_count=8, err_count=0, err_sticky=0, error never 1.
- Golden 5'h0A at index 3, DUT returns 5'h0B, mask=5'h1F -> error=1 for one cycle, err_count=1, first_good=5'h0A, first_my=5'h0B, first_idx=3.
- Same mismatch with mask=5'h1E -> no error, err_count=0, cmp_count increments.
- Two mismatches at indices 2 (5'h04 vs 5'h05) and 6 (5'h10 vs 5'h00) -> err_count=2, first_* still holds the index-2 pair.
- CNT_W=3, 10 mismatching samples -> cmp_count and err_count stick at 7, first_idx=0.
- clear asserted on the same edge as a mismatching compare -> all outputs 0 after that edge. Reset asserted asynchronously between edges -> outputs 0 immediately. After release, the first compare occurs LAT edges after the next valid_in.
